// File: rtl/decomp_fetch_ctrl.sv
// Maps expanded fetch pcs onto compressed ROM words and token-table slots, re-walking the image on redirects.
// Latency: 3 cycles for plain/continuation, 5 for a token's first slot, +2 per plain / +4 per token word scanned.
// Backpressure: one request in flight (req_ready only in IDLE); responses are one-cycle pulses, never stalled.
module decomp_fetch_ctrl #(
  parameter int          ADDR_W    = 9,
  parameter int          MEM_DEPTH = 401,
  parameter int          TOK_LIMIT = 16,
  parameter int          TBL_DEPTH = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [31:0]       req_pc,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_instr,
  output logic [31:0]       rsp_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [3:0]        tbl_idx,
  output logic [1:0]        tbl_slot,
  input  logic [31:0]       tbl_rdata,
  input  logic [2:0]        tbl_len,
  output logic              busy,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, TBL_RD, TBL_OUT, SCAN_RD, SCAN_CHK, SCAN_TBL, SCAN_LEN
  } state_t;

  // last compressed word a scan may inspect before it has run off the image
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  logic [31:0]       cur_pc;    // next sequential expanded pc
  logic [ADDR_W-1:0] mem_ptr;   // compressed word holding cur_pc
  logic [1:0]        slot;      // position of cur_pc inside the current token
  logic [3:0]        cur_tok;   // token being expanded
  logic [31:0]       tgt_pc;    // pc of the accepted request
  logic [ADDR_W-1:0] scan_ptr;  // word under inspection during a redirect
  logic [31:0]       exp_pc;    // expanded pc of the first instruction of scan_ptr
  logic [3:0]        scan_tok;  // token found at scan_ptr

  logic        rd_is_tok;
  logic [3:0]  rd_tok;
  logic        rd_tok_bad;
  logic        len_bad;
  logic [2:0]  slot_inc;
  logic [31:0] exp_end;
  logic [1:0]  tgt_slot;
  logic        scan_last;
  logic        fault;

  // decode ROM/table read data and flag any condition that aborts the request
  always_comb begin
    rd_is_tok  = mem_rdata < 32'(TOK_LIMIT);
    rd_tok     = mem_rdata[3:0];
    rd_tok_bad = 32'(rd_tok) >= 32'(TBL_DEPTH);
    len_bad    = (tbl_len == 3'd0) || (tbl_len > 3'd4);
    slot_inc   = {1'b0, slot} + 3'd1;
    exp_end    = exp_pc + 32'(tbl_len);
    tgt_slot   = 2'(tgt_pc - exp_pc);
    scan_last  = scan_ptr == LAST_PTR;
    fault      = 1'b0;
    case (state)
      DECODE:   fault = rd_is_tok && rd_tok_bad;
      TBL_OUT:  fault = len_bad;
      SCAN_CHK: fault = rd_is_tok ? rd_tok_bad : ((exp_pc != tgt_pc) && scan_last);
      SCAN_LEN: fault = len_bad || (!(tgt_pc < exp_end) && scan_last);
      default:  fault = 1'b0;
    endcase
  end

  // fetch sequencer: all state and outputs registered; ROM addresses are set on entry to their read state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_pc    <= '0;
      mem_ptr   <= '0;
      slot      <= '0;
      cur_tok   <= '0;
      tgt_pc    <= '0;
      scan_ptr  <= '0;
      exp_pc    <= '0;
      scan_tok  <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_pc    <= '0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_addr  <= '0;
      tbl_idx   <= '0;
      tbl_slot  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (fault) begin
        // abort: answer with a NOP and restart sequential tracking from pc 0
        err       <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_instr <= NOP_INSTR;
        rsp_pc    <= tgt_pc;
        cur_pc    <= '0;
        mem_ptr   <= '0;
        slot      <= '0;
        state     <= IDLE;
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              tgt_pc    <= req_pc;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              if (req_pc == cur_pc && slot == 2'd0) begin
                mem_addr <= mem_ptr;
                state    <= FETCH;
              end else if (req_pc == cur_pc) begin
                tbl_idx  <= cur_tok;
                tbl_slot <= slot;
                state    <= TBL_RD;
              end else begin
                scan_ptr <= '0;
                exp_pc   <= '0;
                mem_addr <= '0;
                state    <= SCAN_RD;
              end
            end
          end
          FETCH: state <= DECODE;
          DECODE: begin
            if (!rd_is_tok) begin
              rsp_valid <= 1'b1;
              rsp_instr <= mem_rdata;
              rsp_pc    <= tgt_pc;
              mem_ptr   <= mem_ptr + 1'b1;
              cur_pc    <= cur_pc + 32'd1;
              state     <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cur_tok  <= rd_tok;
              tbl_idx  <= rd_tok;
              tbl_slot <= slot;
              state    <= TBL_RD;
            end
          end
          TBL_RD: state <= TBL_OUT;
          TBL_OUT: begin
            rsp_valid <= 1'b1;
            rsp_instr <= tbl_rdata;
            rsp_pc    <= tgt_pc;
            cur_pc    <= cur_pc + 32'd1;
            if (slot_inc == tbl_len) begin
              slot    <= 2'd0;
              mem_ptr <= mem_ptr + 1'b1;
            end else begin
              slot <= slot_inc[1:0];
            end
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
          SCAN_RD: state <= SCAN_CHK;
          SCAN_CHK: begin
            if (rd_is_tok) begin
              scan_tok <= rd_tok;
              tbl_idx  <= rd_tok;
              tbl_slot <= 2'd0;
              state    <= SCAN_TBL;
            end else if (exp_pc == tgt_pc) begin
              // plain hit: re-read the word through the normal sequential path
              mem_ptr  <= scan_ptr;
              slot     <= 2'd0;
              cur_pc   <= tgt_pc;
              mem_addr <= scan_ptr;
              state    <= FETCH;
            end else begin
              exp_pc   <= exp_pc + 32'd1;
              scan_ptr <= scan_ptr + 1'b1;
              mem_addr <= scan_ptr + 1'b1;
              state    <= SCAN_RD;
            end
          end
          SCAN_TBL: state <= SCAN_LEN;
          SCAN_LEN: begin
            if (tgt_pc < exp_end) begin
              // target lies inside this token: continue as a mid-token fetch
              mem_ptr  <= scan_ptr;
              cur_tok  <= scan_tok;
              slot     <= tgt_slot;
              cur_pc   <= tgt_pc;
              tbl_idx  <= scan_tok;
              tbl_slot <= tgt_slot;
              state    <= TBL_RD;
            end else begin
              exp_pc   <= exp_end;
              scan_ptr <= scan_ptr + 1'b1;
              mem_addr <= scan_ptr + 1'b1;
              state    <= SCAN_RD;
            end
          end
          default: begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decomp_fetch_ctrl.sv
// Bench for decomp_fetch_ctrl: ROM models, directed test-plan table, random requests vs. expansion model.
// Latency: measured in cycles from the accept edge to the rsp_valid pulse.
// Backpressure: requests are issued only while req_ready is high.
module tb_decomp_fetch_ctrl;

  localparam int          MEM_DEPTH = 401;
  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int          BOUND     = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [3:0]  tbl_idx;
  logic [1:0]  tbl_slot;
  logic [31:0] tbl_rdata;
  logic [2:0]  tbl_len;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  decomp_fetch_ctrl #(
    .ADDR_W(9), .MEM_DEPTH(401), .TOK_LIMIT(16), .TBL_DEPTH(10), .NOP_INSTR(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tbl_idx(tbl_idx), .tbl_slot(tbl_slot), .tbl_rdata(tbl_rdata),
    .tbl_len(tbl_len), .busy(busy), .err(err)
  );

  // synchronous ROMs
  logic [31:0] mem [0:511];
  logic [31:0] tbl_data [0:15][0:3];
  logic [2:0]  tbl_lens [0:15];

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    tbl_rdata <= tbl_data[tbl_idx][tbl_slot];
    tbl_len   <= tbl_lens[tbl_idx];
  end

  int n_vec  = 0;
  int n_fail = 0;

  // responses must never be back to back
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && prev_vld === 1'b1) begin
      n_fail++;
      $display("FAIL rsp_pulse: rsp_valid high 2 cycles in a row, required single pulse");
    end
    prev_vld <= rsp_valid;
  end

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", what, act, req);
    end
  endtask

  // ---------------- behavioural model: flat expansion of the image ----------------
  logic [31:0] fx_instr[$];
  int          fx_cost[$];   // scan cycles spent on words before this instruction's word
  bit          fx_tok[$];
  int          fx_slot[$];
  int          vlen;
  int          bad_cost;     // scan cycles up to the point the image becomes unusable
  bit          bad_seq;      // image ends in an illegal token
  int          m_cur;
  bit          m_err;

  task automatic build_model();
    int c;
    int t;
    int l;
    bit stop;
    fx_instr.delete(); fx_cost.delete(); fx_tok.delete(); fx_slot.delete();
    c = 0; stop = 0; bad_seq = 0;
    for (int w = 0; w < MEM_DEPTH && !stop; w++) begin
      if (mem[w] >= 32'd16) begin
        fx_instr.push_back(mem[w]); fx_cost.push_back(c); fx_tok.push_back(1'b0); fx_slot.push_back(0);
        c += 2;
      end else begin
        t = int'(mem[w][3:0]);
        if (t >= 10) begin
          bad_cost = c + 2; bad_seq = 1; stop = 1;
        end else begin
          l = int'(tbl_lens[t]);
          if (l == 0 || l > 4) begin
            bad_cost = c + 4; stop = 1;
          end else begin
            for (int s = 0; s < l; s++) begin
              fx_instr.push_back(tbl_data[t][s]); fx_cost.push_back(c); fx_tok.push_back(1'b1);
              fx_slot.push_back(s);
            end
            c += 4;
          end
        end
      end
    end
    vlen = fx_instr.size();
    if (!stop) bad_cost = c;
  endtask

  task automatic model_req(input int pc, output logic [31:0] e_instr, output int e_lat, output logic e_err);
    if (pc < vlen) begin
      if (pc == m_cur) e_lat = (fx_slot[pc] != 0 || !fx_tok[pc]) ? 3 : 5;
      else             e_lat = fx_cost[pc] + (fx_tok[pc] ? 7 : 5);
      e_instr = fx_instr[pc];
      m_cur   = pc + 1;
    end else begin
      e_lat   = (pc == m_cur && pc == vlen && bad_seq) ? 3 : bad_cost + 1;
      e_instr = NOP;
      m_cur   = 0;
      m_err   = 1;
    end
    e_err = m_err;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cur = 0; m_err = 0;
  endtask

  task automatic do_req(input int pc, output logic [31:0] instr, output logic [31:0] rpc,
                        output int lat, output logic errv);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < BOUND) begin @(posedge clk); #1; k++; end
    req_valid = 1'b1; req_pc = 32'(pc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < BOUND) begin @(posedge clk); #1; lat++; end
    instr = rsp_instr; rpc = rsp_pc; errv = err;
  endtask

  task automatic run_req(input string tag, input int pc, input logic [31:0] e_instr, input int e_lat,
                         input logic e_err);
    logic [31:0] instr;
    logic [31:0] rpc;
    int          lat;
    logic        errv;
    do_req(pc, instr, rpc, lat, errv);
    chk({tag, " instr"}, instr, e_instr);
    chk({tag, " pc"}, rpc, 32'(pc));
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " err"}, 32'(errv), 32'(e_err));
  endtask

  typedef struct {
    bit          do_rst;
    int          pc;
    logic [31:0] instr;
    int          lat;
    logic        e_err;
  } vec_t;

  vec_t tv [14];

  initial begin
    logic [31:0] ei;
    int          el;
    logic        ee;

    // image: plan words, then plain words with a token every 7th word
    for (int i = 0; i < 512; i++) begin
      if (i >= MEM_DEPTH)   mem[i] = 32'h0;
      else if (i % 7 == 5)  mem[i] = 32'(i % 10);
      else                  mem[i] = 32'h1000_0000 | 32'(i);
    end
    mem[0] = 32'h1234_5678; mem[1] = 32'h0000_0003; mem[2] = 32'h9ABC_DEF0;
    for (int t = 0; t < 16; t++) begin
      tbl_lens[t] = (t < 10) ? 3'(t % 4 + 1) : 3'd0;
      for (int s = 0; s < 4; s++) tbl_data[t][s] = 32'hC000_0000 | 32'(t << 8) | 32'(s);
    end
    tbl_lens[3] = 3'd2; tbl_data[3][0] = 32'hAAAA_0001; tbl_data[3][1] = 32'hBBBB_0002;
    build_model();

    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_instr", rsp_instr, 32'd0);
    chk("rst rsp_pc", rsp_pc, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst tbl_idx", 32'(tbl_idx), 32'd0);
    chk("rst tbl_slot", 32'(tbl_slot), 32'd0);

    // directed sequences with hand-derived expectations
    tv[0]  = '{1'b0, 0, 32'h1234_5678, 3, 1'b0};
    tv[1]  = '{1'b0, 1, 32'hAAAA_0001, 5, 1'b0};
    tv[2]  = '{1'b0, 2, 32'hBBBB_0002, 3, 1'b0};
    tv[3]  = '{1'b0, 3, 32'h9ABC_DEF0, 3, 1'b0};
    tv[4]  = '{1'b1, 2, 32'hBBBB_0002, 9, 1'b0};
    tv[5]  = '{1'b0, 3, 32'h9ABC_DEF0, 3, 1'b0};
    tv[6]  = '{1'b0, 1, 32'hAAAA_0001, 9, 1'b0};
    tv[7]  = '{1'b0, 3, 32'h9ABC_DEF0, 11, 1'b0};
    tv[8]  = '{1'b0, 4, 32'h1000_0003, 3, 1'b0};
    tv[9]  = '{1'b0, 0, 32'h1234_5678, 5, 1'b0};
    tv[10] = '{1'b0, 1, 32'hAAAA_0001, 5, 1'b0};
    tv[11] = '{1'b0, 6, 32'hC000_0500, 19, 1'b0};
    tv[12] = '{1'b0, 7, 32'hC000_0501, 3, 1'b0};
    tv[13] = '{1'b0, 8, 32'h1000_0006, 3, 1'b0};
    for (int i = 0; i < 14; i++) begin
      if (tv[i].do_rst) do_reset();
      run_req($sformatf("vec%0d", i), tv[i].pc, tv[i].instr, tv[i].lat, tv[i].e_err);
    end

    // random mix of sequential fetches and redirects against the expansion model
    do_reset();
    for (int i = 0; i < 120; i++) begin
      int pc;
      if ($urandom_range(0, 1) == 1 && m_cur < vlen) pc = m_cur;
      else                                            pc = int'($urandom_range(0, 80));
      model_req(pc, ei, el, ee);
      run_req($sformatf("rnd%0d", i), pc, ei, el, ee);
    end

    // request beyond the image: scan runs off the end
    model_req(500, ei, el, ee);
    run_req("beyond", 500, ei, el, ee);
    model_req(0, ei, el, ee);
    run_req("sticky", 0, ei, el, ee);
    do_reset();
    chk("err cleared", 32'(err), 32'd0);

    // illegal token in the image, reached by scan and sequentially
    mem[1] = 32'h0000_000C;
    build_model();
    do_reset();
    model_req(1, ei, el, ee);
    run_req("badtok scan", 1, ei, el, ee);
    model_req(0, ei, el, ee);
    run_req("badtok seq0", 0, ei, el, ee);
    model_req(1, ei, el, ee);
    run_req("badtok seq1", 1, ei, el, ee);
    mem[1] = 32'h0000_0003;
    build_model();

    // reset while a scan is checking its first word
    do_reset();
    req_valid = 1'b1; req_pc = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_cur = 0; m_err = 0;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    run_req("midrst pc0", 0, 32'h1234_5678, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
